// File: rtl/select_pc_ras_if.sv
// -----------------------------------------------------------------------------
// select_pc_ras_if
//   Bundles the pipeline-facing signals of the fetch-PC selector.
//   master : pipeline/hazard side (drives stage fields, consumes fetch PC)
//   slave  : select_pc_ras itself
//
//   Handshake semantics: there is no valid/ready pair here. Each stage field
//   is a level that is sampled every clock. A retiring ret in W presents
//   W_icode==9 for exactly one cycle. F_stall=1 means the fetch-side fields
//   must not update any prediction state during that cycle.
//
//   Optional macro SELECT_PC_PERF_EN adds the 32-bit performance counters
//   cnt_jmp_miss, cnt_ret_miss and cnt_ret_hit.
// -----------------------------------------------------------------------------
interface select_pc_ras_if #(
    parameter int PC_W      = 64,
    parameter int RAS_DEPTH = 8
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    // Stage inputs
    logic             F_stall;
    logic [3:0]       f_icode;
    logic [PC_W-1:0]  f_valC;
    logic [PC_W-1:0]  f_valP;
    logic [3:0]       M_icode;
    logic             M_cnd;
    logic [PC_W-1:0]  M_valA;
    logic [3:0]       W_icode;
    logic [PC_W-1:0]  W_valM;

    // Outputs of the selector
    logic [PC_W-1:0]  f_pc;
    logic [PC_W-1:0]  F_predPC;
    logic             redirect;
    logic             ras_pred_valid;
    logic [CNT_W-1:0] ras_count;
    logic             retq_ovf;
`ifdef SELECT_PC_PERF_EN
    logic [31:0]      cnt_jmp_miss;
    logic [31:0]      cnt_ret_miss;
    logic [31:0]      cnt_ret_hit;
`endif

    modport master (
        output F_stall, f_icode, f_valC, f_valP,
        output M_icode, M_cnd, M_valA, W_icode, W_valM,
`ifdef SELECT_PC_PERF_EN
        input  cnt_jmp_miss, cnt_ret_miss, cnt_ret_hit,
`endif
        input  f_pc, F_predPC, redirect, ras_pred_valid, ras_count, retq_ovf
    );

    modport slave (
        input  F_stall, f_icode, f_valC, f_valP,
        input  M_icode, M_cnd, M_valA, W_icode, W_valM,
`ifdef SELECT_PC_PERF_EN
        output cnt_jmp_miss, cnt_ret_miss, cnt_ret_hit,
`endif
        output f_pc, F_predPC, redirect, ras_pred_valid, ras_count, retq_ovf
    );
endinterface

// File: rtl/select_pc_ras.sv
// -----------------------------------------------------------------------------
// select_pc_ras
//   Y86-64 fetch-PC selector with a return-address stack (RAS) and an
//   in-flight ret-prediction queue.
//
//   Each cycle f_pc is chosen from (highest priority first):
//     W-stage ret misprediction -> W_valM
//     M-stage not-taken jXX     -> M_valA
//     registered prediction     -> F_predPC
//   A ret retiring in W only redirects when the target predicted at fetch
//   (held in the ret queue) was absent, invalid or different from W_valM.
//
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     bus       : select_pc_ras_if.slave (stage fields in, f_pc/F_predPC,
//                 redirect, ras_pred_valid, ras_count, retq_ovf out)
//
//   Optional macro SELECT_PC_PERF_EN adds saturating 32-bit counters
//   cnt_jmp_miss, cnt_ret_miss, cnt_ret_hit on the interface.
// -----------------------------------------------------------------------------
module select_pc_ras #(
    parameter int              PC_W       = 64,
    parameter int              RAS_DEPTH  = 8,
    parameter int              RETQ_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic         clk,
    input  logic         rst,
    select_pc_ras_if.slave bus
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int QP_W  = (RETQ_DEPTH > 1) ? $clog2(RETQ_DEPTH) : 1;
    localparam int QC_W  = $clog2(RETQ_DEPTH + 1);

    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [QC_W-1:0]  Q_FULL   = QC_W'(RETQ_DEPTH);

    localparam logic [3:0] IC_JXX  = 4'h7;
    localparam logic [3:0] IC_CALL = 4'h8;
    localparam logic [3:0] IC_RET  = 4'h9;

    // Registered state
    logic [PC_W-1:0]  r_pred_pc;
    logic [PC_W-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_ras_ptr;      // next free slot; top is r_ras_ptr-1
    logic [CNT_W-1:0] r_ras_count;
    logic             r_q_valid [RETQ_DEPTH];
    logic [PC_W-1:0]  r_q_tgt   [RETQ_DEPTH];
    logic [QP_W-1:0]  r_q_rd;
    logic [QP_W-1:0]  r_q_wr;
    logic [QC_W-1:0]  r_q_cnt;
    logic             r_retq_ovf;

    // Combinational next-state
    logic             w_w_ret;
    logic             w_wret_miss;
    logic             w_mjmp_miss;
    logic             w_redirect;
    logic             w_q_pop;
    logic             w_fetch;
    logic             w_ras_nonempty;
    logic [PTR_W-1:0] w_ras_top_idx;
    logic [PC_W-1:0]  w_ras_top;
    logic             w_ras_push;
    logic             w_ras_pop;
    logic [CNT_W-1:0] w_ras_cnt_base;
    logic [CNT_W-1:0] w_ras_cnt_nxt;
    logic [PTR_W-1:0] w_ras_ptr_nxt;
    logic             w_q_push;
    logic             w_q_full;
    logic             w_q_wr_en;
    logic [QC_W-1:0]  w_q_cnt_base;
    logic [QP_W-1:0]  w_q_rd_base;
    logic [QP_W-1:0]  w_q_wr_base;
    logic [QC_W-1:0]  w_q_cnt_nxt;
    logic [QP_W-1:0]  w_q_wr_nxt;
    logic [PC_W-1:0]  w_pred_nxt;
    logic [PC_W-1:0]  w_f_pc;

    function automatic logic [QP_W-1:0] q_inc(input logic [QP_W-1:0] p);
        return (p == QP_W'(RETQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // W-stage ret check against the oldest queued prediction
        w_w_ret     = (bus.W_icode == IC_RET);
        w_wret_miss = w_w_ret && ((r_q_cnt == '0) ||
                                  !r_q_valid[r_q_rd] ||
                                  (r_q_tgt[r_q_rd] != bus.W_valM));
        w_q_pop     = w_w_ret && (r_q_cnt != '0);

        w_mjmp_miss = (bus.M_icode == IC_JXX) && !bus.M_cnd;
        w_redirect  = w_wret_miss || w_mjmp_miss;

        if (w_wret_miss)      w_f_pc = bus.W_valM;
        else if (w_mjmp_miss) w_f_pc = bus.M_valA;
        else                  w_f_pc = r_pred_pc;

        // A redirect clears the RAS before this cycle's fetch update, so the
        // fetch side must see it as empty.
        w_ras_cnt_base = w_redirect ? '0 : r_ras_count;
        w_ras_nonempty = (w_ras_cnt_base != '0);
        w_ras_top_idx  = r_ras_ptr - 1'b1;
        w_ras_top      = r_ras[w_ras_top_idx];

        w_fetch    = !bus.F_stall;
        w_ras_push = w_fetch && (bus.f_icode == IC_CALL);
        w_ras_pop  = w_fetch && (bus.f_icode == IC_RET) && w_ras_nonempty;
        w_q_push   = w_fetch && (bus.f_icode == IC_RET);

        // RAS: push overwrites the oldest entry when full (circular pointer),
        // count saturates.
        w_ras_ptr_nxt = r_ras_ptr;
        w_ras_cnt_nxt = w_ras_cnt_base;
        if (w_ras_push) begin
            w_ras_ptr_nxt = r_ras_ptr + 1'b1;
            w_ras_cnt_nxt = (w_ras_cnt_base == RAS_FULL) ? RAS_FULL
                                                         : w_ras_cnt_base + 1'b1;
        end else if (w_ras_pop) begin
            w_ras_ptr_nxt = w_ras_top_idx;
            w_ras_cnt_nxt = w_ras_cnt_base - 1'b1;
        end

        // Ret queue: W pop first, then flush on redirect, then fetch push.
        // Fullness is judged after the pop so pop+push in one cycle is legal.
        w_q_cnt_base = w_redirect ? '0 : (r_q_cnt - QC_W'(w_q_pop));
        w_q_rd_base  = w_redirect ? '0 : (w_q_pop ? q_inc(r_q_rd) : r_q_rd);
        w_q_wr_base  = w_redirect ? '0 : r_q_wr;
        w_q_full     = (w_q_cnt_base == Q_FULL);
        w_q_wr_en    = w_q_push && !w_q_full;
        w_q_cnt_nxt  = w_q_wr_en ? w_q_cnt_base + 1'b1 : w_q_cnt_base;
        w_q_wr_nxt   = w_q_wr_en ? q_inc(w_q_wr_base) : w_q_wr_base;

        if ((bus.f_icode == IC_JXX) || (bus.f_icode == IC_CALL))
            w_pred_nxt = bus.f_valC;
        else if ((bus.f_icode == IC_RET) && w_ras_nonempty)
            w_pred_nxt = w_ras_top;
        else
            w_pred_nxt = bus.f_valP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_pc   <= RESET_PC;
            r_ras_ptr   <= '0;
            r_ras_count <= '0;
            r_q_rd      <= '0;
            r_q_wr      <= '0;
            r_q_cnt     <= '0;
            r_retq_ovf  <= 1'b0;
        end else begin
            if (w_fetch)
                r_pred_pc <= w_pred_nxt;
            r_ras_ptr   <= w_ras_ptr_nxt;
            r_ras_count <= w_ras_cnt_nxt;
            r_q_rd      <= w_q_rd_base;
            r_q_wr      <= w_q_wr_nxt;
            r_q_cnt     <= w_q_cnt_nxt;
            if (w_q_push && w_q_full)
                r_retq_ovf <= 1'b1;
        end
    end

    // Storage arrays need no reset: occupancy counters gate every read.
    always_ff @(posedge clk) begin
        if (!rst && w_ras_push)
            r_ras[r_ras_ptr] <= bus.f_valP;
        if (!rst && w_q_wr_en) begin
            r_q_valid[w_q_wr_base] <= w_ras_nonempty;
            r_q_tgt[w_q_wr_base]   <= w_ras_nonempty ? w_ras_top : bus.f_valP;
        end
    end

    assign bus.f_pc           = w_f_pc;
    assign bus.F_predPC       = r_pred_pc;
    assign bus.redirect       = w_redirect;
    assign bus.ras_pred_valid = (bus.f_icode == IC_RET) && w_ras_nonempty;
    assign bus.ras_count      = r_ras_count;
    assign bus.retq_ovf       = r_retq_ovf;

`ifdef SELECT_PC_PERF_EN
    logic [31:0] r_cnt_jmp_miss;
    logic [31:0] r_cnt_ret_miss;
    logic [31:0] r_cnt_ret_hit;
    logic        w_wret_hit;

    assign w_wret_hit = w_w_ret && !w_wret_miss;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_jmp_miss <= '0;
            r_cnt_ret_miss <= '0;
            r_cnt_ret_hit  <= '0;
        end else begin
            // Jump misses count even when a ret miss wins the f_pc priority.
            if (w_mjmp_miss && (r_cnt_jmp_miss != '1))
                r_cnt_jmp_miss <= r_cnt_jmp_miss + 1'b1;
            if (w_wret_miss && (r_cnt_ret_miss != '1))
                r_cnt_ret_miss <= r_cnt_ret_miss + 1'b1;
            if (w_wret_hit && (r_cnt_ret_hit != '1))
                r_cnt_ret_hit <= r_cnt_ret_hit + 1'b1;
        end
    end

    assign bus.cnt_jmp_miss = r_cnt_jmp_miss;
    assign bus.cnt_ret_miss = r_cnt_ret_miss;
    assign bus.cnt_ret_hit  = r_cnt_ret_hit;
`endif

endmodule

// File: tb/tb_select_pc_ras.sv
// -----------------------------------------------------------------------------
// tb_select_pc_ras
//   Directed testbench for select_pc_ras (PC_W=64, RAS_DEPTH=8, RETQ_DEPTH=4,
//   RESET_PC=0). Inputs change #1 after the rising edge; combinational
//   outputs are sampled #1 after that, registered outputs #1 after the edge.
// -----------------------------------------------------------------------------
module tb_select_pc_ras;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    select_pc_ras_if #(.PC_W(64), .RAS_DEPTH(8)) bus ();

    select_pc_ras #(
        .PC_W(64), .RAS_DEPTH(8), .RETQ_DEPTH(4), .RESET_PC(64'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.F_stall = 1'b1;
        bus.f_icode = 4'h1;
        bus.f_valC  = '0;
        bus.f_valP  = '0;
        bus.M_icode = 4'h1;
        bus.M_cnd   = 1'b0;
        bus.M_valA  = '0;
        bus.W_icode = 4'h1;
        bus.W_valM  = '0;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [63:0] valc,
                         input logic [63:0] valp);
        bus.F_stall = 1'b0;
        bus.f_icode = ic;
        bus.f_valC  = valc;
        bus.f_valP  = valp;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---- 1. Reset ----
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_predpc", bus.F_predPC, 64'h0);
        check("rst_fpc", bus.f_pc, 64'h0);
        check("rst_ras_count", 64'(bus.ras_count), 64'd0);
        check("rst_redirect", 64'(bus.redirect), 64'd0);
        check("rst_ovf", 64'(bus.retq_ovf), 64'd0);
`ifdef SELECT_PC_PERF_EN
        check("rst_cnt_hit", 64'(bus.cnt_ret_hit), 64'd0);
`endif

        // ---- 2. Call / ret hit ----
        fetch(4'h8, 64'h100, 64'h19);
        #1 check("call_pred_valid", 64'(bus.ras_pred_valid), 64'd0);
        tick();
        check("call_predpc", bus.F_predPC, 64'h100);
        check("call_ras_count", 64'(bus.ras_count), 64'd1);
        fetch(4'h9, 64'h0, 64'h101);
        #1 check("ret_pred_valid", 64'(bus.ras_pred_valid), 64'd1);
        tick(); idle();
        check("ret_predpc", bus.F_predPC, 64'h19);
        check("ret_ras_count", 64'(bus.ras_count), 64'd0);
        bus.W_icode = 4'h9; bus.W_valM = 64'h19;
        #1 check("hit_redirect", 64'(bus.redirect), 64'd0);
        check("hit_fpc", bus.f_pc, 64'h19);
        tick(); idle();
`ifdef SELECT_PC_PERF_EN
        check("hit_cnt", 64'(bus.cnt_ret_hit), 64'd1);
`endif

        // ---- 3. Ret miss, flush of RAS and queue ----
        fetch(4'h8, 64'h100, 64'h19); tick();
        fetch(4'h9, 64'h0, 64'h101);  tick();
        fetch(4'h8, 64'h300, 64'h105); tick(); idle();
        check("miss_pre_ras", 64'(bus.ras_count), 64'd1);
        check("miss_pre_pred", bus.F_predPC, 64'h300);
        bus.W_icode = 4'h9; bus.W_valM = 64'h40;
        #1 check("miss_fpc", bus.f_pc, 64'h40);
        check("miss_redirect", 64'(bus.redirect), 64'd1);
        tick(); idle();
        check("miss_ras_flush", 64'(bus.ras_count), 64'd0);
        check("miss_pred_hold", bus.F_predPC, 64'h300);
        // The queued 0x19 prediction must have been flushed: empty -> miss
        bus.W_icode = 4'h9; bus.W_valM = 64'h19;
        #1 check("flush_redirect", 64'(bus.redirect), 64'd1);
        check("flush_fpc", bus.f_pc, 64'h19);
        tick(); idle();
`ifdef SELECT_PC_PERF_EN
        check("miss_cnt", 64'(bus.cnt_ret_miss), 64'd2);
`endif

        // ---- 4. Jump mispredict ----
        fetch(4'h8, 64'h180, 64'h120); tick();
        fetch(4'h7, 64'h200, 64'h189); tick(); idle();
        check("jxx_predpc", bus.F_predPC, 64'h200);
        check("jxx_ras", 64'(bus.ras_count), 64'd1);
        bus.M_icode = 4'h7; bus.M_cnd = 1'b1; bus.M_valA = 64'h2A;
        #1 check("jtaken_redirect", 64'(bus.redirect), 64'd0);
        check("jtaken_fpc", bus.f_pc, 64'h200);
        bus.M_cnd = 1'b0;
        #1 check("jmiss_fpc", bus.f_pc, 64'h2A);
        check("jmiss_redirect", 64'(bus.redirect), 64'd1);
        tick(); idle();
        check("jmiss_ras_clear", 64'(bus.ras_count), 64'd0);
`ifdef SELECT_PC_PERF_EN
        check("jmiss_cnt", 64'(bus.cnt_jmp_miss), 64'd1);
`endif

        // ---- 5. Priority ----
        bus.W_icode = 4'h9; bus.W_valM = 64'h80;
        bus.M_icode = 4'h7; bus.M_cnd = 1'b0; bus.M_valA = 64'h90;
        #1 check("prio_fpc", bus.f_pc, 64'h80);
        check("prio_redirect", 64'(bus.redirect), 64'd1);
        tick(); idle();
`ifdef SELECT_PC_PERF_EN
        check("prio_cnt_jmp", 64'(bus.cnt_jmp_miss), 64'd2);
        check("prio_cnt_ret", 64'(bus.cnt_ret_miss), 64'd3);
`endif
        // Correct ret coinciding with a jump miss still takes M_valA
        fetch(4'h8, 64'h400, 64'h30); tick();
        fetch(4'h9, 64'h0, 64'h401);  tick(); idle();
        check("prio2_pred", bus.F_predPC, 64'h30);
        bus.W_icode = 4'h9; bus.W_valM = 64'h30;
        bus.M_icode = 4'h7; bus.M_cnd = 1'b0; bus.M_valA = 64'h77;
        #1 check("prio2_fpc", bus.f_pc, 64'h77);
        check("prio2_redirect", 64'(bus.redirect), 64'd1);
        tick(); idle();
`ifdef SELECT_PC_PERF_EN
        check("prio2_cnt_hit", 64'(bus.cnt_ret_hit), 64'd2);
        check("prio2_cnt_jmp", 64'(bus.cnt_jmp_miss), 64'd3);
`endif

        // ---- 6. RAS wrap, stall, queue overflow ----
        for (int i = 0; i < 9; i++) begin
            fetch(4'h8, 64'h1000 + 64'(i) * 64'h100, 64'h20 + 64'(i));
            tick();
        end
        idle();
        check("wrap_ras_count", 64'(bus.ras_count), 64'd8);
        check("wrap_predpc", bus.F_predPC, 64'h1800);
        bus.f_icode = 4'h9; bus.f_valP = 64'h999;  // F_stall stays 1
        #1 check("stall_pred_valid", 64'(bus.ras_pred_valid), 64'd1);
        tick(); idle();
        check("stall_predpc", bus.F_predPC, 64'h1800);
        check("stall_ras", 64'(bus.ras_count), 64'd8);
        check("stall_ovf", 64'(bus.retq_ovf), 64'd0);
        for (int k = 0; k < 8; k++) begin
            fetch(4'h9, 64'h0, 64'h900 + 64'(k));
            tick();
            check("wrap_ret_pred", bus.F_predPC, 64'h28 - 64'(k));
            check("wrap_ret_ras", 64'(bus.ras_count), 64'(7 - k));
            check("wrap_ret_ovf", 64'(bus.retq_ovf), (k >= 4) ? 64'd1 : 64'd0);
        end
        // Ninth ret finds the stack empty: 0x20 was overwritten
        fetch(4'h9, 64'h0, 64'h9AA);
        #1 check("empty_pred_valid", 64'(bus.ras_pred_valid), 64'd0);
        tick(); idle();
        check("empty_predpc", bus.F_predPC, 64'h9AA);
        check("empty_ras", 64'(bus.ras_count), 64'd0);
        // Queue holds 0x28, 0x27, 0x26, 0x25 from the first four rets
        bus.W_icode = 4'h9; bus.W_valM = 64'h28;
        #1 check("q_head_hit", 64'(bus.redirect), 64'd0);
        tick(); idle();
        bus.W_icode = 4'h9; bus.W_valM = 64'h99;
        #1 check("q_next_miss", 64'(bus.redirect), 64'd1);
        check("q_next_fpc", bus.f_pc, 64'h99);
        tick(); idle();
`ifdef SELECT_PC_PERF_EN
        check("end_cnt_hit", 64'(bus.cnt_ret_hit), 64'd3);
        check("end_cnt_miss", 64'(bus.cnt_ret_miss), 64'd4);
`endif

        // ---- Reset mid-operation ----
        fetch(4'h8, 64'h700, 64'h50); tick(); idle();
        check("pre_rst_pred", bus.F_predPC, 64'h700);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_pred", bus.F_predPC, 64'h0);
        check("mid_rst_fpc", bus.f_pc, 64'h0);
        check("mid_rst_ras", 64'(bus.ras_count), 64'd0);
        check("mid_rst_ovf", 64'(bus.retq_ovf), 64'd0);
`ifdef SELECT_PC_PERF_EN
        check("mid_rst_cnt", 64'(bus.cnt_jmp_miss), 64'd0);
`endif

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
